// File: rtl/seg_pkg.sv
// seg_pkg: glyph codes and segment patterns shared by the scan driver and
// the upstream display driver. Segment patterns are active-low in bit
// order {dp,g,f,e,d,c,b,a}, with the decimal point off.
package seg_pkg;

    // Glyph codes above the decimal digits
    localparam logic [3:0] GLY_H     = 4'd10;
    localparam logic [3:0] GLY_E     = 4'd11;
    localparam logic [3:0] GLY_L     = 4'd12;
    localparam logic [3:0] GLY_O     = 4'd13;
    localparam logic [3:0] GLY_BLANK = 4'd14;
    localparam logic [3:0] GLY_DASH  = 4'd15;

    // Segment patterns
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    // One frame-buffer entry
    typedef struct packed {
        logic       point;
        logic [3:0] num;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{point: 1'b0, num: GLY_BLANK};

    // Glyph code to segment pattern, decimal point off
    function automatic logic [7:0] glyph_segments(input logic [3:0] num);
        logic [7:0] s;
        case (num)
            4'd0:      s = SEG_0;
            4'd1:      s = SEG_1;
            4'd2:      s = SEG_2;
            4'd3:      s = SEG_3;
            4'd4:      s = SEG_4;
            4'd5:      s = SEG_5;
            4'd6:      s = SEG_6;
            4'd7:      s = SEG_7;
            4'd8:      s = SEG_8;
            4'd9:      s = SEG_9;
            GLY_H:     s = SEG_H;
            GLY_E:     s = SEG_E;
            GLY_L:     s = SEG_L;
            GLY_O:     s = SEG_O;
            GLY_DASH:  s = SEG_DASH;
            default:   s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit-update stream, display controls and the
// physical segment/anode outputs of the scan driver.
//   digit_stb  : single-cycle write strobe
//   pos        : digit index to write
//   num        : glyph code
//   point      : decimal point, 1 = lit
//   enable     : 0 blanks the display
//   brightness : duty level, 7 = full, 0 = 1/8
//   seg        : active-low segments {dp,g,f,e,d,c,b,a}
//   seg_pos    : active-low one-hot anode select
interface seg_scan_driver_if;

    logic       digit_stb;
    logic [2:0] pos;
    logic [3:0] num;
    logic       point;
    logic       enable;
    logic [2:0] brightness;
    logic [7:0] seg;
    logic [7:0] seg_pos;

    // Display driver side
    modport master (
        output digit_stb, pos, num, point, enable, brightness,
        input  seg, seg_pos
    );

    // Scan driver side
    modport slave (
        input  digit_stb, pos, num, point, enable, brightness,
        output seg, seg_pos
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: combinational {point, num} -> active-low segment pattern.
//   point_i : decimal point, 1 = lit (clears seg_o[7], even on a blank glyph)
//   num_i   : glyph code
//   seg_o   : segments {dp,g,f,e,d,c,b,a}, active-low
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic       point_i,
    input  logic [3:0] num_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = glyph_segments(num_i);
        if (point_i) begin
            seg_o[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit common-anode seven-segment scan driver.
// Captures digit updates into an 8-entry frame buffer and multiplexes it
// onto the display, one slot of 2^SLOT_W cycles per digit, with BLANK_CYC
// cycles of anode dead-time at the start of every slot and 8-level PWM.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : digit stream, enable/brightness in; seg/seg_pos out (registered)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SLOT_W    = 10,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);

    localparam logic [SLOT_W-1:0] BLANK_TH = SLOT_W'(BLANK_CYC);

    digit_t            frame_q [8];
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]        scan_idx_q, scan_idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [7:0]        seg_pos_q, seg_pos_d;
    logic [7:0]        dec_seg;
    logic              lit;

    // The load reads the registered entry, so a write on the load edge is
    // seen only on the digit's next visit.
    seg_glyph_decode u_decode (
        .point_i (frame_q[scan_idx_q].point),
        .num_i   (frame_q[scan_idx_q].num),
        .seg_o   (dec_seg)
    );

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (&slot_cnt_q) begin
            scan_idx_d = scan_idx_q + 3'd1;
        end

        // Top three slot bits form the PWM phase within the slot
        lit = bus.enable
              && (slot_cnt_q >= BLANK_TH)
              && (slot_cnt_q[SLOT_W-1 -: 3] <= bus.brightness);

        seg_pos_d = lit ? ~(8'b1 << scan_idx_q) : SEG_OFF;

        // Segments change only at slot start, inside the dead-time
        seg_d = seg_q;
        if (!bus.enable) begin
            seg_d = SEG_OFF;
        end else if (slot_cnt_q == '0) begin
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= SEG_OFF;
            seg_pos_q  <= SEG_OFF;
            for (int unsigned i = 0; i < 8; i++) begin
                frame_q[i] <= DIGIT_BLANK;
            end
        end else begin
            slot_cnt_q <= slot_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            seg_pos_q  <= seg_pos_d;
            if (bus.digit_stb) begin
                frame_q[bus.pos] <= '{point: bus.point, num: bus.num};
            end
        end
    end

    assign bus.seg     = seg_q;
    assign bus.seg_pos = seg_pos_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with a short slot (64 cycles, 4 dead-time).
module tb_seg_scan_driver;

    localparam int SLOT_W = 6;
    localparam int BLANK  = 4;
    localparam int SLOT   = 1 << SLOT_W;
    localparam int FRAME  = 8 * SLOT;

    localparam logic [7:0] REF_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h89, 8'h86, 8'hC7, 8'hC0, 8'hFF, 8'hBF
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_driver_if bus();

    seg_scan_driver #(.SLOT_W(SLOT_W), .BLANK_CYC(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_seg(input logic [4:0] d);
        logic [7:0] s;
        logic [3:0] n;
        n = d[3:0];
        s = REF_TBL[n];
        if (d[4]) s = s & 8'h7F;
        return s;
    endfunction

    logic [4:0]  mbuf [8];
    int unsigned mcyc;          // edges since the last reset edge
    int unsigned msc, msi;
    logic [7:0]  exp_seg, exp_pos;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mcyc    <= 0;
            for (int i = 0; i < 8; i++) mbuf[i] <= 5'd14;
            exp_seg <= 8'hFF;
            exp_pos <= 8'hFF;
            model_ok <= 1'b1;
        end else begin
            msc = mcyc % SLOT;
            msi = (mcyc / SLOT) % 8;
            if (!bus.enable) exp_seg <= 8'hFF;
            else if (msc == 0) exp_seg <= ref_seg(mbuf[msi]);
            if (bus.enable && msc >= BLANK && (msc * 8) / SLOT <= bus.brightness)
                exp_pos <= 8'hFF ^ (8'h01 << msi);
            else
                exp_pos <= 8'hFF;
            if (bus.digit_stb) mbuf[bus.pos] <= {bus.point, bus.num};
            mcyc <= mcyc + 1;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            vectors++;
            if ({bus.seg, bus.seg_pos} !== {exp_seg, exp_pos}) begin
                miscompares++;
                $display("FAIL model cyc=%0d: seg=%h seg_pos=%h, expected seg=%h seg_pos=%h",
                         mcyc, bus.seg, bus.seg_pos, exp_seg, exp_pos);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Advance at least one cycle, then stop at the negedge where mcyc lands on
    // (slot idx, offset rel); outputs then reflect counter offset rel-1.
    task automatic wait_at(input int idx, input int rel);
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            @(negedge clk);
            if (int'(mcyc % SLOT) == rel && int'((mcyc / SLOT) % 8) == idx) return;
        end
        miscompares++;
        $display("FAIL wait_at timeout: slot %0d offset %0d not reached", idx, rel);
    endtask

    task automatic write_digit(input logic [2:0] p, input logic [3:0] n, input logic pt);
        bus.digit_stb = 1'b1;
        bus.pos = p;
        bus.num = n;
        bus.point = pt;
        @(negedge clk);
        bus.digit_stb = 1'b0;
    endtask

    // Called at the negedge just before the release edge
    task automatic check_release();
        check("reset seg", bus.seg, 8'hFF);
        check("reset seg_pos", bus.seg_pos, 8'hFF);
        for (int k = 1; k <= BLANK + 1; k++) begin
            @(negedge clk);
            check("first anode", bus.seg_pos, (k == BLANK + 1) ? 8'hFE : 8'hFF);
            check("first seg", bus.seg, 8'hFF);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] pos;
        logic [3:0] num;
        logic       pt;
        logic [7:0] want;
    } vec_t;

    vec_t tbl [16];

    task automatic run_batch(input int base);
        wait_at(7, SLOT / 2);
        for (int i = 0; i < 8; i++)
            if (tbl[base + i].wr) write_digit(tbl[base + i].pos, tbl[base + i].num, tbl[base + i].pt);
        for (int i = 0; i < 8; i++) begin
            wait_at(int'(tbl[base + i].pos), SLOT / 2);
            check("table seg", bus.seg, tbl[base + i].want);
            check("table seg_pos", bus.seg_pos, 8'hFF ^ (8'h01 << tbl[base + i].pos));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 4'd0,  1'b0, 8'hFF};
        tbl[1]  = '{1'b1, 3'd1, 4'd10, 1'b0, 8'h89};
        tbl[2]  = '{1'b1, 3'd2, 4'd11, 1'b0, 8'h86};
        tbl[3]  = '{1'b1, 3'd3, 4'd12, 1'b0, 8'hC7};
        tbl[4]  = '{1'b1, 3'd4, 4'd12, 1'b0, 8'hC7};
        tbl[5]  = '{1'b1, 3'd5, 4'd13, 1'b0, 8'hC0};
        tbl[6]  = '{1'b0, 3'd6, 4'd0,  1'b0, 8'hFF};
        tbl[7]  = '{1'b0, 3'd7, 4'd0,  1'b0, 8'hFF};
        tbl[8]  = '{1'b1, 3'd0, 4'd0,  1'b0, 8'hC0};
        tbl[9]  = '{1'b1, 3'd1, 4'd1,  1'b0, 8'hF9};
        tbl[10] = '{1'b1, 3'd2, 4'd5,  1'b1, 8'h12};
        tbl[11] = '{1'b1, 3'd3, 4'd3,  1'b0, 8'hB0};
        tbl[12] = '{1'b1, 3'd4, 4'd4,  1'b0, 8'h99};
        tbl[13] = '{1'b1, 3'd5, 4'd6,  1'b1, 8'h02};
        tbl[14] = '{1'b1, 3'd6, 4'd7,  1'b0, 8'hF8};
        tbl[15] = '{1'b1, 3'd7, 4'd14, 1'b1, 8'h7F};

        bus.digit_stb  = 1'b0;
        bus.pos        = 3'd0;
        bus.num        = 4'd0;
        bus.point      = 1'b0;
        bus.enable     = 1'b1;
        bus.brightness = 3'd7;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_release();

        // HELLO, then digits with points
        run_batch(0);
        run_batch(8);

        // Brightness 3 on digit 2: lit for offsets BLANK .. SLOT/2-1
        bus.brightness = 3'd3;
        wait_at(2, BLANK);
        check("bright below blank", bus.seg_pos, 8'hFF);
        wait_at(2, BLANK + 1);
        check("bright first lit", bus.seg_pos, 8'hFB);
        wait_at(2, SLOT / 2);
        check("bright last lit", bus.seg_pos, 8'hFB);
        check("bright point seg", bus.seg, 8'h12);
        wait_at(2, SLOT / 2 + 1);
        check("bright past duty", bus.seg_pos, 8'hFF);
        bus.brightness = 3'd7;

        // Write collides with the load of digit 3
        wait_at(3, 0);
        write_digit(3'd3, 4'd8, 1'b0);
        wait_at(3, SLOT / 2);
        check("collision old", bus.seg, 8'hB0);
        wait_at(3, SLOT / 2);
        check("collision new", bus.seg, 8'h80);

        // Enable drop mid-slot, then re-enable
        wait_at(4, SLOT / 2);
        bus.enable = 1'b0;
        @(negedge clk);
        check("disable seg", bus.seg, 8'hFF);
        check("disable seg_pos", bus.seg_pos, 8'hFF);
        wait_at(4, SLOT - 4);
        bus.enable = 1'b1;
        wait_at(5, 0);
        check("reenable hold seg", bus.seg, 8'hFF);
        check("reenable anode", bus.seg_pos, 8'hEF);
        wait_at(5, 1);
        check("reenable load seg", bus.seg, 8'h02);

        // Reset mid-frame clears the buffer and restarts at digit 0
        wait_at(5, SLOT / 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_release();
        wait_at(1, SLOT / 2);
        check("post-reset digit1", bus.seg, 8'hFF);
        wait_at(2, SLOT / 2);
        check("post-reset digit2", bus.seg, 8'hFF);

        // Random traffic against the model
        for (int c = 0; c < 6000; c++) begin
            bus.digit_stb = ($urandom_range(3) == 0);
            bus.pos   = 3'($urandom_range(7));
            bus.num   = 4'($urandom_range(15));
            bus.point = 1'($urandom_range(1));
            if ($urandom_range(299) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(199) == 0) bus.brightness = 3'($urandom_range(7));
            @(negedge clk);
        end
        bus.digit_stb = 1'b0;
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Physical 8-digit seven-segment scan driver and the receiving end of the display driver's digit stream. It captures each `{pos, num, point}` digit update into an 8-entry frame buffer, then time-multiplexes the buffer onto the board's common-anode display. Scanning includes a per-digit dead-time against ghosting and 8-level brightness PWM. It sits between the display driver and the FPGA segment/anode pins.

## Interface
Parameters:
- `SLOT_W`, 10: log2 of clk cycles per digit slot; slot length is 2^SLOT_W.
- `BLANK_CYC`, 16: dead-time cycles at the start of each slot with all anodes off. Legal range 2 ≤ BLANK_CYC < 2^(SLOT_W-3).

Ports:
- `clk` input, 1: system clock. One clock; all logic is on its rising edge.
- `rst_n` input, 1: reset, synchronous and active-low.
- `digit_stb` input, 1: single-cycle write strobe, already synchronous to `clk`.
- `pos` input, 3: digit index to write.
- `num` input, 4: glyph code.
- `point` input, 1: decimal point for that digit; 1 = lit.
- `enable` input, 1: 0 blanks the display.
- `brightness` input, 3: duty level; 7 = full, 0 = 1/8.
- `seg` output, 8: active-low segments, bit order `{dp,g,f,e,d,c,b,a}`.
- `seg_pos` output, 8: active-low one-hot anode select; bit i drives digit i.

## Operation
- **Frame buffer:** 8 × 5 bits, `{point, num}`.
  - Reset value of every entry is `{0, 14}` (blank, dp off).
  - On `digit_stb=1` at a clock edge: `buf[pos] <= {point, num}`. No other writes occur.
- **Glyph codes** (value of `seg` with dp off):
  - Digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - 10=H 89, 11=E 86, 12=L C7, 13=O C0, 14=blank FF, 15=dash BF.
  - `point=1` clears `seg[7]`, including on a blank glyph.
- **Scan counters:**
  - `slot_cnt` is SLOT_W bits and increments every cycle, wrapping to 0.
  - `scan_idx` is 3 bits and increments on the edge where `slot_cnt` wraps from all-ones to 0. It wraps 7→0.
- **Segment latch:** on each edge where the current `slot_cnt==0`, `seg <= decode(buf[scan_idx])`. Otherwise `seg` holds.
- **Anode drive:** on every edge, `seg_pos <= lit ? ~(8'b1 << scan_idx) : 8'hFF`.
  - `lit = enable && slot_cnt >= BLANK_CYC && slot_cnt[SLOT_W-1 -: 3] <= brightness`.
- **`enable=0`:**
  - `seg_pos` goes to FF and `seg` goes to FF on the next edge.
  - Counters keep running and buffer writes still occur.
  - After `enable` returns to 1, `seg` reloads at the next slot start.
- **Boundary cases:**
  - Write on the same edge as a seg load of the same index: the load takes the old entry. The new value appears the next time that digit is scanned.
  - A mid-slot write to the displayed digit does not alter `seg` until that digit's next slot (no tearing).
  - `brightness` and `enable` changes take effect on the next edge with no glitch filtering.

## Timing
- **Reset** (`rst_n=0` at an edge): `seg=FF`, `seg_pos=FF`, `slot_cnt=0`, `scan_idx=0`, buffer all blank.
  - Reset mid-scan behaves the same and clears the buffer.
  - First anode assertion is digit 0 at cycle BLANK_CYC+1 after reset release.
- **Latency:**
  - Outputs are registered, one cycle behind the counter state.
  - Write-to-display latency is at most 8·2^SLOT_W + 1 cycles.
- **Full frame:** 8·2^SLOT_W cycles. With defaults, the 8192-cycle frame gives ≈6.1 kHz refresh at 50 MHz.
- **Within each slot:**
  - `seg` changes only at relative cycle 1, while anodes are guaranteed off (BLANK_CYC ≥ 2).
  - Exactly one `seg_pos` bit is low at any time, or none.

## Structure
- **Shared package `seg_pkg`:**
  - Glyph code constants `GLY_H=10`, `GLY_E=11`, `GLY_L=12`, `GLY_O=13`, `GLY_BLANK=14`, `GLY_DASH=15`.
  - Segment pattern constants and the `SEG_OFF=8'hFF` constant.
  - The display driver imports the same codes.
- **Sub-module `seg_glyph_decode`:** combinational, `{point, num}` → `seg[7:0]`. It is unit-testable on its own.
- **Top level:** buffer, counters, PWM compare and output registers.

## Test plan
- **Reset:** release reset, no writes, `brightness=7`, `enable=1` → `seg=FF` throughout; `seg_pos` cycles FE, FD, … 7F, each low for 2^SLOT_W−BLANK_CYC cycles, with FF gaps of BLANK_CYC.
- **HELLO:** write pos1..5 = 10, 11, 12, 12, 13 → during slots 1..5 `seg` = 89, 86, C7, C7, C0; slots 0, 6, 7 show FF.
- **Point and brightness:** write pos2 = `{1, 5}` → `seg=12` in slot 2. With `brightness=3`, digit 2's anode is low only for `slot_cnt` in [BLANK_CYC, 2^(SLOT_W-1)−1].
- **Write collision:** strobe pos3=8 on the edge where `scan_idx=3` and `slot_cnt=0` → that slot shows the old value; the next visit to digit 3 shows 80.
- **Enable and reset:** `enable=0` mid-slot → `seg_pos=FF` and `seg=FF` on the next edge; re-enable → correct glyph from the next slot start. Assert `rst_n=0` mid-frame → all outputs FF, buffer blank, scanning restarts at digit 0.
